bus_rsp_mux3: RTL
=================

BUS_RSP_MUX3 -- requirements
Module: bus_rsp_mux3

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of serial read-data bits per transaction.
REQ-002 Parameter TIMEOUT, default 16: idle-cycle limit while waiting for slave data.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 sel  input  2  slave select: 00 = slave 1, 01 = slave 2, 10 = slave 3, 11 = none.
REQ-006 req_start  input  1  one-cycle pulse, master starts a read transaction to sel.
REQ-007 s1_rdata, s2_rdata, s3_rdata  input  1 each  serial read-data bit from slave n.
REQ-008 s1_rvalid, s2_rvalid, s3_rvalid  input  1 each  slave n rdata bit valid this cycle.
REQ-009 m_rdata  output  1  routed read-data bit to master.
REQ-010 m_rvalid  output  1  m_rdata valid.
REQ-011 m_busy  output  1  transaction in progress.
REQ-012 m_done  output  1  one-cycle pulse, transaction completed.
REQ-013 m_err  output  1  one-cycle pulse, invalid select or timeout.

Function
REQ-014 The FSM SHALL have states IDLE, ROUTE, DRAIN.
REQ-015 In IDLE, req_start=1 with sel in {00,01,10} SHALL latch sel into sel_q, clear bit and idle counters, and enter ROUTE next cycle.
REQ-016 In IDLE, req_start=1 with sel=11 SHALL pulse m_err the next cycle and remain IDLE.
REQ-017 In ROUTE, m_rdata/m_rvalid SHALL be registered copies of the sel_q slave's rdata/rvalid: 1-cycle latency.
REQ-018 Unselected slaves' rdata/rvalid SHALL never affect any output.
REQ-019 The bit counter SHALL increment on each selected rvalid; when it reaches DATA_WIDTH the FSM SHALL enter DRAIN.
REQ-020 DRAIN SHALL last exactly one cycle, assert m_done, then return to IDLE.
REQ-021 The idle counter SHALL increment each ROUTE cycle without selected rvalid and reset to 0 on selected rvalid.
REQ-022 When the idle counter reaches TIMEOUT, the FSM SHALL pulse m_err, drive m_rvalid=0, and return to IDLE.
REQ-023 A partial transfer SHALL NOT assert m_done.
REQ-024 m_busy SHALL be 1 in ROUTE and DRAIN, 0 in IDLE.
REQ-025 req_start while m_busy=1 SHALL be ignored; sel_q SHALL NOT change mid-transaction.
REQ-026 Selected rvalid on the same cycle the idle counter would hit TIMEOUT SHALL win: the bit is accepted and no error is raised.
REQ-027 Counters SHALL be sized as clog2(max(DATA_WIDTH, TIMEOUT)+1) bits and SHALL NOT wrap.
REQ-028 m_done and m_err SHALL never assert in the same cycle.

Reset
REQ-029 rstn=0 SHALL immediately force IDLE, sel_q=0, both counters 0, and m_rdata, m_rvalid, m_busy, m_done, m_err all 0.
REQ-030 Reset asserted mid-transaction SHALL abort it with no m_done or m_err pulse; after release the block SHALL accept a new req_start.

Structure
REQ-031 State encoding, select codes (SEL_S1/S2/S3/NONE), and DATA_WIDTH/TIMEOUT defaults SHALL live in the shared bus package.
REQ-032 The routing mux SHALL be a single flat module with no sub-modules; the select encoding SHALL match the bus address decoder.

Verification
REQ-033 sel=01, req_start, slave 2 sends 8 bits 10110010 on consecutive cycles -> m_rdata reproduces 10110010 one cycle later, m_done pulses once, m_busy returns to 0.
REQ-034 sel=00 transaction while slaves 2 and 3 toggle rvalid/rdata -> output stream contains only slave 1 bits.
REQ-035 sel=11 with req_start -> m_err pulses one cycle, m_busy stays 0.
REQ-036 sel=10, slave 3 sends 3 bits then goes silent -> m_err pulses exactly 16 cycles after the last bit, no m_done.
REQ-037 rstn dropped after 4 of 8 bits -> outputs 0 asynchronously; a new sel=00 transaction then completes normally.
REQ-038 Second req_start with sel=10 during a sel=00 transaction -> ignored; routing stays on slave 1 until m_done.

Source files
------------

// File: rtl/bus_rsp_mux3_pkg.sv
// Shared bus definitions: FSM state encoding, slave select codes, default
// transaction sizing and the counter-width helper used by the response mux.
package bus_rsp_mux3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUTE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Same codes the bus address decoder produces for the three slave windows.
    localparam logic [1:0] SEL_S1   = 2'b00;
    localparam logic [1:0] SEL_S2   = 2'b01;
    localparam logic [1:0] SEL_S3   = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int TIMEOUT_DEF    = 16;

    // Counters must hold the larger of the two limits without wrapping.
    function automatic int cnt_width(input int dw, input int to);
        int mx;
        mx = (dw > to) ? dw : to;
        return $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/bus_rsp_mux3.sv
// Serial read-response mux: routes one of three slave bit streams back to the
// master for a DATA_WIDTH-bit transaction, with idle timeout and bad-select
// error reporting. All outputs are flop-driven.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | waiting for req_start; sel=11 gives an error pulse
//  ST_ROUTE | forwarding latched slave's bits, counting bits and idle cycles
//  ST_DRAIN | single cycle after the last bit, m_done high
module bus_rsp_mux3
    import bus_rsp_mux3_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] sel,
    input  logic       req_start,
    input  logic       s1_rdata,
    input  logic       s2_rdata,
    input  logic       s3_rdata,
    input  logic       s1_rvalid,
    input  logic       s2_rvalid,
    input  logic       s3_rvalid,
    output logic       m_rdata,
    output logic       m_rvalid,
    output logic       m_busy,
    output logic       m_done,
    output logic       m_err
);

    localparam int CW = cnt_width(DATA_WIDTH, TIMEOUT);
    localparam logic [CW-1:0] BITS_LIM = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] IDLE_LIM = CW'(TIMEOUT);

    state_t        r_state;
    logic [1:0]    r_sel_q;
    logic [CW-1:0] r_bit_cnt;
    logic [CW-1:0] r_idle_cnt;
    logic          r_rdata;
    logic          r_rvalid;
    logic          r_busy;
    logic          r_done;
    logic          r_err;

    state_t        w_state_nx;
    logic [1:0]    w_sel_nx;
    logic [CW-1:0] w_bit_nx;
    logic [CW-1:0] w_idle_nx;
    logic          w_rdata_nx;
    logic          w_rvalid_nx;
    logic          w_done_nx;
    logic          w_err_nx;

    logic          w_sl_rdata;
    logic          w_sl_rvalid;
    logic [CW-1:0] w_bit_inc;
    logic [CW-1:0] w_idle_inc;

    // Pick the latched slave's stream; other slaves never reach the outputs.
    always_comb begin
        w_sl_rdata  = 1'b0;
        w_sl_rvalid = 1'b0;
        case (r_sel_q)
            SEL_S1: begin
                w_sl_rdata  = s1_rdata;
                w_sl_rvalid = s1_rvalid;
            end
            SEL_S2: begin
                w_sl_rdata  = s2_rdata;
                w_sl_rvalid = s2_rvalid;
            end
            SEL_S3: begin
                w_sl_rdata  = s3_rdata;
                w_sl_rvalid = s3_rvalid;
            end
            default: begin
                w_sl_rdata  = 1'b0;
                w_sl_rvalid = 1'b0;
            end
        endcase
    end

    // Saturating increments; the FSM leaves ROUTE before either could pass its limit.
    always_comb begin
        w_bit_inc  = (r_bit_cnt  == BITS_LIM) ? r_bit_cnt  : r_bit_cnt  + CW'(1);
        w_idle_inc = (r_idle_cnt == IDLE_LIM) ? r_idle_cnt : r_idle_cnt + CW'(1);
    end

    // Next-state and next-output decode; a selected bit takes priority over timeout.
    always_comb begin
        w_state_nx  = r_state;
        w_sel_nx    = r_sel_q;
        w_bit_nx    = r_bit_cnt;
        w_idle_nx   = r_idle_cnt;
        w_rdata_nx  = 1'b0;
        w_rvalid_nx = 1'b0;
        w_done_nx   = 1'b0;
        w_err_nx    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_start) begin
                    if (sel == SEL_NONE) begin
                        w_err_nx = 1'b1;
                    end else begin
                        w_sel_nx   = sel;
                        w_bit_nx   = '0;
                        w_idle_nx  = '0;
                        w_state_nx = ST_ROUTE;
                    end
                end
            end
            ST_ROUTE: begin
                w_rdata_nx  = w_sl_rdata;
                w_rvalid_nx = w_sl_rvalid;
                if (w_sl_rvalid) begin
                    w_idle_nx = '0;
                    w_bit_nx  = w_bit_inc;
                    if (w_bit_inc == BITS_LIM) begin
                        w_state_nx = ST_DRAIN;
                        w_done_nx  = 1'b1;
                    end
                end else begin
                    w_idle_nx = w_idle_inc;
                    if (w_idle_inc == IDLE_LIM) begin
                        w_state_nx  = ST_IDLE;
                        w_err_nx    = 1'b1;
                        w_rvalid_nx = 1'b0;
                        w_rdata_nx  = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_sel_q    <= SEL_S1;
            r_bit_cnt  <= '0;
            r_idle_cnt <= '0;
            r_rdata    <= 1'b0;
            r_rvalid   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_sel_q    <= w_sel_nx;
            r_bit_cnt  <= w_bit_nx;
            r_idle_cnt <= w_idle_nx;
            r_rdata    <= w_rdata_nx;
            r_rvalid   <= w_rvalid_nx;
            r_busy     <= (w_state_nx != ST_IDLE);
            r_done     <= w_done_nx;
            r_err      <= w_err_nx;
        end
    end

    assign m_rdata  = r_rdata;
    assign m_rvalid = r_rvalid;
    assign m_busy   = r_busy;
    assign m_done   = r_done;
    assign m_err    = r_err;

endmodule
